// File: rtl/product_accumulator.sv
// Accumulates a counted run of signed 64-bit products into a saturating ACC_W-bit sum.
// One product per clock in ACCUM; the result is held in DONE until the consumer takes it.
module product_accumulator #(
  parameter int CNT_W = 8,
  parameter int ACC_W = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [63:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic             ovf;

  logic             xfer;
  logic             accept;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_sat;

  assign xfer   = prod_valid && (state == ACCUM);
  assign accept = start && (state == IDLE);

  // Signed overflow happens only when both operands share a sign the result lacks;
  // the clamp direction follows that common operand sign.
  always_comb begin
    ext     = ACC_W'($signed(prod));
    raw     = acc + ext;
    add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
    acc_sat = raw;
    if (add_ovf) begin
      acc_sat = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (xfer && (remaining == CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else if (accept) begin
      acc       <= '0;
      remaining <= len;
      ovf       <= 1'b0;
    end else if (xfer) begin
      acc       <= acc_sat;
      remaining <= remaining - CNT_W'(1);
      if (add_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

  assign sum      = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed checks of product_accumulator: a 72-bit instance for the main flow and
// a 64-bit instance where saturation is reachable.
module tb_product_accumulator;

  logic        clk;
  logic        reset;

  logic        start;
  logic [7:0]  len;
  logic [63:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [71:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic        overflow;
  logic        busy;

  logic        start64;
  logic [7:0]  len64;
  logic [63:0] prod64;
  logic        prod_valid64;
  logic        prod_ready64;
  logic [63:0] sum64;
  logic        sum_valid64;
  logic        sum_ready64;
  logic        overflow64;
  logic        busy64;

  int tests = 0;
  int fails = 0;

  product_accumulator #(.CNT_W(8), .ACC_W(72)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .overflow(overflow), .busy(busy)
  );

  product_accumulator #(.CNT_W(8), .ACC_W(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .len(len64), .prod(prod64),
    .prod_valid(prod_valid64), .prod_ready(prod_ready64), .sum(sum64),
    .sum_valid(sum_valid64), .sum_ready(sum_ready64), .overflow(overflow64), .busy(busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [71:0] gap_sum [7];
  logic        gap_vld [7];
  logic        gap_pv  [7];

  initial begin
    int k;
    gap_pv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_sum = '{72'd1, 72'd1, 72'd1, 72'd3, 72'd6, 72'd6, 72'd10};
    gap_vld = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b0; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; sum_ready = 1'b0;
    start64 = 1'b0; len64 = '0; prod64 = '0; prod_valid64 = 1'b0; sum_ready64 = 1'b0;
    tick();
    chk("rst_sum", sum, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    tick();

    // basic run of three products
    reset = 1'b1;
    start = 1'b1; len = 8'd3;
    tick();
    chk("run3_prod_ready", prod_ready, 1);
    chk("run3_busy", busy, 1);
    start = 1'b0; len = 8'd99;
    prod_valid = 1'b1; prod = 64'd5;
    tick();
    prod = -64'sd2;
    tick();
    chk("run3_mid_sum", sum, 3);
    chk("run3_mid_valid", sum_valid, 0);
    prod = 64'd7;
    tick();
    prod_valid = 1'b0;
    chk("run3_sum", sum, 10);
    chk("run3_sum_valid", sum_valid, 1);
    chk("run3_overflow", overflow, 0);
    chk("run3_done_prod_ready", prod_ready, 0);
    sum_ready = 1'b1;
    tick();
    chk("run3_idle_busy", busy, 0);
    chk("run3_idle_sum_kept", sum, 10);

    // zero-length request
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_sum_valid", sum_valid, 1);
    chk("len0_sum", sum, 0);
    chk("len0_prod_ready", prod_ready, 0);
    tick();
    chk("len0_idle", busy, 0);

    // gaps in prod_valid hold state
    sum_ready = 1'b0;
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      prod_valid = gap_pv[i];
      prod = gap_pv[i] ? 64'(k + 1) : 64'hDEAD;
      tick();
      if (gap_pv[i]) k++;
      chk($sformatf("gap_sum_%0d", i), sum, gap_sum[i]);
      chk($sformatf("gap_valid_%0d", i), sum_valid, gap_vld[i]);
    end
    prod_valid = 1'b0;

    // DONE held with sum_ready low; start must be ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd2;
      tick();
      chk($sformatf("hold_sum_%0d", i), sum, 10);
      chk($sformatf("hold_valid_%0d", i), sum_valid, 1);
    end
    sum_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_release_busy", busy, 0);
    chk("hold_release_sum", sum, 10);

    // asynchronous reset mid-accumulation
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod = 64'd1;
    tick();
    prod = 64'd2;
    tick();
    prod_valid = 1'b0;
    chk("abort_partial", sum, 3);
    reset = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_prod_ready", prod_ready, 0);
    chk("abort_sum_valid", sum_valid, 0);
    #1;
    reset = 1'b1;
    start = 1'b1; len = 8'd1;
    tick();
    chk("after_rst_ready", prod_ready, 1);
    start = 1'b0; prod_valid = 1'b1; prod = 64'd9;
    tick();
    prod_valid = 1'b0;
    chk("after_rst_sum", sum, 9);
    chk("after_rst_valid", sum_valid, 1);
    tick();

    // saturation on the 64-bit instance
    start64 = 1'b1; len64 = 8'd2;
    tick();
    start64 = 1'b0; prod_valid64 = 1'b1; prod64 = 64'h7FFF_FFFF_FFFF_FFFF;
    tick();
    chk("sat_first_ovf", overflow64, 0);
    prod64 = 64'd1;
    tick();
    prod_valid64 = 1'b0;
    chk("sat_sum", sum64, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sat_overflow", overflow64, 1);
    chk("sat_valid", sum_valid64, 1);
    sum_ready64 = 1'b1;
    tick();
    chk("sat_idle_ovf_kept", overflow64, 1);
    start64 = 1'b1; len64 = 8'd1;
    tick();
    start64 = 1'b0;
    chk("sat_restart_ovf", overflow64, 0);
    chk("sat_restart_sum", sum64, 0);
    prod_valid64 = 1'b1; prod64 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    prod_valid64 = 1'b0;
    chk("neg1_sum", sum64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("neg1_overflow", overflow64, 0);
    chk("neg1_valid", sum_valid64, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter SHALL be: CNT_W, 8, width of the product-count input and internal counter.
REQ-002 Parameter SHALL be: ACC_W, 72, accumulator and result width; legal range 64..128.
REQ-003 Port SHALL be: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port SHALL be: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port SHALL be: start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 Port SHALL be: len  input  CNT_W  number of products to accumulate; sampled with start.
REQ-007 Port SHALL be: prod  input  64  signed two's-complement product from the 32x32 multiplier stage.
REQ-008 Port SHALL be: prod_valid  input  1  prod holds a valid product this cycle.
REQ-009 Port SHALL be: prod_ready  output  1  block accepts prod this cycle.
REQ-010 Port SHALL be: sum  output  ACC_W  signed accumulated result.
REQ-011 Port SHALL be: sum_valid  output  1  sum is final and stable.
REQ-012 Port SHALL be: sum_ready  input  1  consumer accepts sum.
REQ-013 Port SHALL be: overflow  output  1  saturation occurred during the current/last accumulation.
REQ-014 Port SHALL be: busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-016 IDLE: start=1 SHALL clear acc to 0, clear overflow, load remaining=len; next state ACCUM if len!=0, DONE if len==0.
REQ-017 start SHALL be ignored in ACCUM and DONE; len SHALL be ignored except on the accepting start cycle.
REQ-018 prod_ready SHALL be 1 only in ACCUM (registered-state decode, no combinational path from prod_valid).
REQ-019 Transfer SHALL occur on a rising edge with prod_valid=1 and prod_ready=1; only transferred products are accumulated.
REQ-020 Per transfer: acc <= sat(acc + sign_extend(prod, ACC_W)); remaining <= remaining-1.
REQ-021 Saturation: on signed overflow of the ACC_W addition, acc SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) by operand sign, and overflow SHALL set; overflow is sticky until next accepted start.
REQ-022 Transfer with remaining==1 SHALL move ACCUM->DONE; sum_valid SHALL assert the cycle after the last transfer (latency 1 clock).
REQ-023 ACCUM with prod_valid=0 SHALL hold all state; no timeout.
REQ-024 sum SHALL equal acc continuously; sum_valid SHALL be 1 only in DONE; sum, overflow SHALL be stable while sum_valid=1 and sum_ready=0.
REQ-025 DONE with sum_ready=1 SHALL move to IDLE on that edge; start in that same cycle SHALL be ignored (IDLE first).
REQ-026 In IDLE, sum and overflow SHALL retain last result until next accepted start.
REQ-027 Throughput: one product per clock in ACCUM with prod_valid held high.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, acc=0, remaining=0, overflow=0, sum=0, sum_valid=0, prod_ready=0, busy=0.
REQ-029 reset asserted mid-ACCUM or in DONE SHALL abort the operation; no partial sum SHALL be presented afterwards.
REQ-030 First start SHALL be accepted on the first rising edge with reset=1 after deassertion.

Verification
REQ-031 start, len=3; prods 5, -2, 7 on consecutive cycles -> sum=10, sum_valid 1 cycle after third transfer, overflow=0.
REQ-032 start, len=0 -> next cycle DONE, sum=0, sum_valid=1, prod_ready never 1.
REQ-033 ACC_W=64, len=2, prods 0x7FFFFFFFFFFFFFFF, 1 -> sum=0x7FFFFFFFFFFFFFFF, overflow=1; then len=1, prod -1 -> overflow cleared, sum=-1.
REQ-034 len=4, prod_valid toggled 1,0,0,1,1,0,1 with prods 1..4 -> sum=10 only after fourth transfer; gaps hold state.
REQ-035 DONE with sum_ready=0 for 5 cycles, start pulsed -> sum stable, start ignored; sum_ready=1 -> IDLE next edge.
REQ-036 reset=0 asynchronously after 2 of 4 transfers -> all outputs 0 immediately; new start len=1, prod 9 -> sum=9.
